// File: rtl/sega_pad_reader.sv
// Scans a Mega Drive 3-button pad (select on pin_d7) and builds the NES-order joystick byte.
// Optional PAD_DEBOUNCE_EN: joy only follows a candidate seen on DEBOUNCE_SCANS consecutive scans.
module sega_pad_reader #(
  parameter int IDLE_CYCLES    = 50000,
  parameter int HALF_CYCLES    = 250,
  parameter int SETTLE         = 200,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clock_25,
  input  logic       reset_n,
  input  logic       pin_d1,
  input  logic       pin_d2,
  input  logic       pin_d3,
  input  logic       pin_d4,
  input  logic       pin_d6,
  input  logic       pin_d9,
  output logic       pin_d7,
  output logic [7:0] joy,
  output logic       present,
  output logic       scan_done
);

  localparam int CW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  if (SETTLE >= HALF_CYCLES || SETTLE < 1 || HALF_CYCLES > IDLE_CYCLES || DEBOUNCE_SCANS < 1)
  begin : g_bad_cfg
    $error("sega_pad_reader: inconsistent timing or debounce parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_COMMIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pin_d7_q, pin_d7_d;
  logic          hi_cap_en, lo_cap_en, commit;

  // Pin order everywhere below: {d9, d6, d4, d3, d2, d1}
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pin_d9, pin_d6, pin_d4, pin_d3, pin_d2, pin_d1};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pin_d7_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pin_d7_q <= pin_d7_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cnt_q == IDLE_LAST) state_d = S_HI;
      S_HI:     if (cnt_q == HALF_LAST) state_d = S_LO;
      S_LO:     if (cnt_q == HALF_LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    cnt_d    = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    // Registered select so the pad never sees a decode glitch
    pin_d7_d = (state_d != S_LO);
  end

  always_comb begin
    commit    = (state_q == S_COMMIT);
    hi_cap_en = (state_q == S_HI) && (cnt_q == SETTLE_LAST);
    lo_cap_en = (state_q == S_LO) && (cnt_q == SETTLE_LAST);
  end

  assign pin_d7    = pin_d7_q;
  assign scan_done = commit;

  // hi_q = {c, b, right, left, down, up}; lo_q = {start, a, det}
  logic [5:0] hi_q;
  logic [2:0] lo_q;

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_cap_en) hi_q <= sync2_q;
      if (lo_cap_en) lo_q <= {sync2_q[5], sync2_q[4], sync2_q[3] & sync2_q[2]};
    end
  end

  logic       det, ud_ok, lr_ok;
  logic [7:0] cand;

  always_comb begin
    det   = lo_q[0];
    ud_ok = !(hi_q[0] & hi_q[1]);
    lr_ok = !(hi_q[2] & hi_q[3]);
    cand  = 8'h00;
    if (det) begin
      cand = {hi_q[3] & lr_ok, hi_q[2] & lr_ok, hi_q[1] & ud_ok, hi_q[0] & ud_ok,
              lo_q[2], hi_q[5], hi_q[4], lo_q[1]};
    end
  end

  logic [7:0] joy_q, joy_d;
  logic       present_q, present_d;

`ifdef PAD_DEBOUNCE_EN
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MW-1:0] MATCH_FULL = MW'(DEBOUNCE_SCANS);

  logic [7:0]    cand_q, cand_d;
  logic [MW-1:0] match_q, match_d;

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      cand_q  <= '0;
      match_q <= '0;
    end else begin
      cand_q  <= cand_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    cand_d    = cand_q;
    match_d   = match_q;
    joy_d     = joy_q;
    present_d = present_q;
    if (commit) begin
      present_d = det;
      cand_d    = cand;
      if (cand != cand_q)            match_d = MW'(1);
      else if (match_q < MATCH_FULL) match_d = match_q + MW'(1);
      // Removal is reported at once; only presses and releases are filtered
      if (!det)                      joy_d = 8'h00;
      else if (match_d >= MATCH_FULL) joy_d = cand;
    end
  end
`else
  always_comb begin
    joy_d     = joy_q;
    present_d = present_q;
    if (commit) begin
      present_d = det;
      joy_d     = cand;
    end
  end
`endif

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      joy_q     <= 8'h00;
      present_q <= 1'b0;
    end else begin
      joy_q     <= joy_d;
      present_q <= present_d;
    end
  end

  assign joy     = joy_q;
  assign present = present_q;

endmodule
